// File: rtl/dbus_dmem_resp.sv
// Data-bus responder: word-organised RAM behind the LSU dbus, registered one-cycle ack.
// Optional DBUS_RESP_ERR_EN flags out-of-range and misaligned accesses on err_o.
module dbus_dmem_resp #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_i,
  input  logic        ld_req_i,
  input  logic        st_req_i,
  input  logic [31:0] w_data_i,
  input  logic [1:0]  st_ops_i,
  input  logic        flush_i,
  output logic [31:0] r_data_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [1:0] ST_OPS_NONE = 2'd0;
  localparam logic [1:0] ST_OPS_SB   = 2'd1;
  localparam logic [1:0] ST_OPS_SH   = 2'd2;
  localparam logic [1:0] ST_OPS_SW   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, next_state;

  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       data_q;
  logic [3:0]        be_q;
  logic              bad_q;
  logic [31:0]       r_data_q;
  logic              err_q;
  logic [31:0]       mem [DEPTH];

  logic              req;
  logic              accept;
  logic              enter_resp;
  logic [ADDR_W-1:0] idx_in;
  logic [31:0]       data_in;
  logic [3:0]        be_in;
  logic              bad_in;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       acc_data;
  logic [3:0]        acc_be;
  logic              acc_bad;

  assign req    = ld_req_i | st_req_i;
  assign accept = (state == S_IDLE) && req && !flush_i;
  assign idx_in = addr_i[ADDR_W+1:2];

  always_comb begin
    be_in   = 4'b0000;
    data_in = w_data_i;
    if (st_req_i) begin
      case (st_ops_i)
        ST_OPS_SB: begin
          be_in   = 4'b0001 << addr_i[1:0];
          data_in = {4{w_data_i[7:0]}};
        end
        ST_OPS_SH: begin
          be_in   = 4'b0011 << {addr_i[1], 1'b0};
          data_in = {2{w_data_i[15:0]}};
        end
        ST_OPS_SW: be_in = 4'b1111;
        ST_OPS_NONE: be_in = 4'b0000;
        default: be_in = 4'b0000;
      endcase
    end
  end

`ifdef DBUS_RESP_ERR_EN
  assign bad_in = (|addr_i[31:ADDR_W+2]) ||
                  (st_req_i && (((st_ops_i == ST_OPS_SH) && addr_i[0]) ||
                                ((st_ops_i == ST_OPS_SW) && (addr_i[1:0] != 2'b00))));
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:ADDR_W+2];
  assign bad_in         = 1'b0;
`endif

  // With zero wait states the access commits straight from IDLE, so use the live inputs there.
  assign acc_idx    = (state == S_IDLE) ? idx_in  : idx_q;
  assign acc_data   = (state == S_IDLE) ? data_in : data_q;
  assign acc_be     = (state == S_IDLE) ? be_in   : be_q;
  assign acc_bad    = (state == S_IDLE) ? bad_in  : bad_q;
  assign enter_resp = (next_state == S_RESP) && (state != S_RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      r_data_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state <= next_state;
      if (accept)
        cnt <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
      else if ((state == S_WAIT) && (cnt != 4'd0))
        cnt <= cnt - 4'd1;
      if (enter_resp) begin
        r_data_q <= acc_bad ? 32'd0 : mem[acc_idx];
        err_q    <= acc_bad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q  <= idx_in;
      data_q <= data_in;
      be_q   <= be_in;
      bad_q  <= bad_in;
    end
  end

  // Old word is sampled into r_data_q on this same edge, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && !acc_bad) begin
      for (int b = 0; b < 4; b++)
        if (acc_be[b])
          mem[acc_idx][8*b +: 8] <= acc_data[8*b +: 8];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept) next_state = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (flush_i || !req)    next_state = S_IDLE;
        else if (cnt == 4'd0)   next_state = S_RESP;
      end
      S_RESP: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ack_o    = (state == S_RESP);
    err_o    = ack_o & err_q;
    r_data_o = r_data_q;
  end

endmodule

// File: tb/tb_dbus_dmem_resp.sv
// Bench for dbus_dmem_resp: two instances (WAIT_STATES 0 and 3) checked against a word model.
// Follows DBUS_RESP_ERR_EN the same way as the design.
module tb_dbus_dmem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [1:0]  st_ops;
  logic        flush;
  logic        ld_req0, st_req0, ld_req3, st_req3;
  logic [31:0] r_data0, r_data3;
  logic        ack0, ack3, err0, err3;

  logic        sel;
  logic        sel_ack, sel_err;
  logic [31:0] sel_rdata;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];

  always #5 clk = ~clk;

  assign sel_ack   = sel ? ack3    : ack0;
  assign sel_err   = sel ? err3    : err0;
  assign sel_rdata = sel ? r_data3 : r_data0;

  dbus_dmem_resp #(.DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .addr_i(addr), .ld_req_i(ld_req0), .st_req_i(st_req0),
    .w_data_i(w_data), .st_ops_i(st_ops), .flush_i(flush),
    .r_data_o(r_data0), .ack_o(ack0), .err_o(err0)
  );

  dbus_dmem_resp #(.DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .addr_i(addr), .ld_req_i(ld_req3), .st_req_i(st_req3),
    .w_data_i(w_data), .st_ops_i(st_ops), .flush_i(flush),
    .r_data_o(r_data3), .ack_o(ack3), .err_o(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int inst, input logic ld, input logic st);
    if (inst == 0) begin ld_req0 = ld; st_req0 = st; end
    else           begin ld_req3 = ld; st_req3 = st; end
  endtask

  task automatic checkOutput(input logic got, input int cyc, input logic ld);
    exp_t e;
    e = sb.pop_front();
    check({e.tag, "/ack"}, 32'(got), 32'd1);
    if (got) begin
      check({e.tag, "/latency"}, 32'(cyc), 32'(e.lat));
      check({e.tag, "/err"}, 32'(sel_err), 32'(e.err));
      if (ld || e.err) check({e.tag, "/rdata"}, sel_rdata, e.data);
    end
  endtask

  // Model the access, queue the expectation, run the handshake and compare on ack.
  task automatic applyStimulus(input int inst, input logic ld, input logic st, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] op, input string tag);
    exp_t        e;
    int          key;
    logic [31:0] w;
    logic        bad;
    int          cyc;
    logic        got;
    int          l;
    key = inst * 4096 + int'(a[11:2]);
    w   = model.exists(key) ? model[key] : 32'h0;
`ifdef DBUS_RESP_ERR_EN
    bad = (a[31:12] != 20'd0) || (st && (((op == 2'd2) && a[0]) || ((op == 2'd3) && (a[1:0] != 2'd0))));
`else
    bad = 1'b0;
`endif
    e.tag  = tag;
    e.err  = bad;
    e.data = bad ? 32'h0 : w;
    e.lat  = (inst == 0) ? 1 : 4;
    sb.push_back(e);
    if (st && !bad) begin
      case (op)
        2'd1: begin l = int'(a[1:0]); w[8*l +: 8] = d[7:0]; end
        2'd2: begin l = a[1] ? 2 : 0; w[8*l +: 8] = d[7:0]; w[8*(l+1) +: 8] = d[15:8]; end
        2'd3: w = d;
        default: ;
      endcase
      model[key] = w;
    end
    sel = (inst != 0); addr = a; w_data = d; st_ops = op;
    drive_req(inst, ld, st);
    cyc = 0; got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (sel_ack) got = 1'b1;
    end
    drive_req(inst, 1'b0, 1'b0);
    checkOutput(got, cyc, ld);
    @(posedge clk); #1;
    check({tag, "/strobe"}, 32'(sel_ack), 32'd0);
  endtask

  task automatic count_acks(input int n, output int acks);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (ack3) acks++;
    end
  endtask

  initial begin
    int acks;
    rst_n = 1'b0; addr = '0; w_data = '0; st_ops = 2'd0; flush = 1'b0; sel = 1'b0;
    ld_req0 = 1'b0; st_req0 = 1'b0; ld_req3 = 1'b0; st_req3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/ack0", 32'(ack0), 32'd0);
    check("reset/err0", 32'(err0), 32'd0);
    check("reset/rdata0", r_data0, 32'd0);
    check("reset/ack3", 32'(ack3), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd3, "sw_10");
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd0, "lw_10");
    applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'h11223344, 2'd3, "sw_base");
    applyStimulus(0, 1'b0, 1'b1, 32'h13, 32'h000000AA, 2'd1, "sb_13");
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd0, "lw_after_sb");
    applyStimulus(0, 1'b0, 1'b1, 32'h12, 32'h00005566, 2'd2, "sh_12");
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd0, "lw_after_sh");
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h00000005, 2'd3, "sw_20");
    applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'h00000007, 2'd3, "amo_20");
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 2'd0, "st_none");
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 2'd0, "lw_after_amo");
    applyStimulus(0, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 2'd3, "sw_0");
    applyStimulus(0, 1'b1, 1'b0, 32'h1000, 32'h0, 2'd0, "lw_wrap");
    applyStimulus(0, 1'b0, 1'b1, 32'h32, 32'h0BADF00D, 2'd3, "sw_misaligned");
    applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'h0, 2'd0, "lw_30");

    applyStimulus(1, 1'b0, 1'b1, 32'h40, 32'h12345678, 2'd3, "ws3_sw_40");
    applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0, 2'd0, "ws3_lw_40");

    sel = 1'b1; addr = 32'h40; w_data = 32'h99999999; st_ops = 2'd3;
    drive_req(1, 1'b0, 1'b1);
    @(posedge clk); #1;
    acks = ack3 ? 1 : 0;
    @(posedge clk); #1;
    if (ack3) acks++;
    flush = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack3) acks++;
    end
    flush = 1'b0;
    drive_req(1, 1'b0, 1'b0);
    begin
      int more;
      count_acks(8, more);
      check("flush/no_ack", 32'(acks + more), 32'd0);
    end
    applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0, 2'd0, "lw_after_flush");

    addr = 32'h40; w_data = 32'h77777777; st_ops = 2'd3;
    drive_req(1, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_wait/ack", 32'(ack3), 32'd0);
    check("rst_wait/err", 32'(err3), 32'd0);
    check("rst_wait/rdata", r_data3, 32'd0);
    rst_n = 1'b1;
    drive_req(1, 1'b0, 1'b0);
    count_acks(8, acks);
    check("rst_wait/no_ack", 32'(acks), 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0, 2'd0, "lw_after_rst");
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd0, "ws0_lw_after_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
